ascii_angle_parser: RTL
=======================

# ascii_angle_parser

Receive-side command parser for the Bluetooth servo path. It takes bytes from the UART receiver and accumulates ASCII decimal digits terminated by CR or LF into one 8-bit binary angle. It range-checks the value and presents it with a one-cycle valid strobe. Its output feeds the binary-to-decimal conversion stage (for display) and the servo PWM stage.

## Interface
Parameters:
- MAX_VALUE, default 180: largest accepted angle; larger values are rejected.
- MAX_DIGITS, default 3: maximum digits per command, leading zeros included.
- TIMEOUT_CYCLES, default 2_500_000: inter-byte idle limit (100 ms at 25 MHz).

Ports:
- i_Clk, input, 1: system clock; all logic in this single domain.
- i_Rst_L, input, 1: asynchronous, active-low reset.
- i_RX_DV, input, 1: one-cycle strobe; i_RX_Byte is valid this cycle.
- i_RX_Byte, input, 8: received byte.
- o_Angle, output, 8: last accepted angle, held until the next accepted command.
- o_Angle_DV, output, 1: one-cycle pulse when o_Angle is updated.
- o_Error, output, 1: one-cycle pulse on a rejected command.
- o_Busy, output, 1: high whenever the state is not IDLE.

## Operation
Byte classes:
- Digit: 0x30–0x39.
- Terminator: 0x0D or 0x0A.
- Anything else is invalid.

Internal registers:
- 10-bit accumulator r_Acc (max 999).
- 2-bit digit counter r_Count.

Accumulate rule: r_Acc <= r_Acc*10 + (byte − 0x30). The computation is done at 10+ bits and is never truncated before the range check.

States and transitions:
- **IDLE**
  - Digit: load r_Acc = digit, r_Count = 1, go to ACCUM.
  - Terminator: ignored, stays in IDLE. This absorbs the second byte of a CR/LF pair.
  - Invalid: pulse o_Error, go to DISCARD.
- **ACCUM**
  - Digit with r_Count < MAX_DIGITS: accumulate, r_Count+1.
  - Digit with r_Count = MAX_DIGITS: pulse o_Error, go to DISCARD.
  - Terminator with r_Acc ≤ MAX_VALUE: o_Angle <= r_Acc[7:0], pulse o_Angle_DV, go to IDLE.
  - Terminator with r_Acc > MAX_VALUE: pulse o_Error, o_Angle unchanged, go to IDLE.
  - Invalid: pulse o_Error, go to DISCARD.
  - Timeout: pulse o_Error, go to IDLE.
- **DISCARD**
  - All bytes ignored until a terminator arrives, then go to IDLE with no further pulse.
  - Timeout: go to IDLE silently.

General rules:
- r_Acc and r_Count clear on every entry to IDLE.
- Leading zeros count as digits: "007" is accepted as 7, "0007" is an error.
- o_Angle_DV and o_Error are mutually exclusive and never assert in the same cycle.

## Timing
Reset values (asynchronous on i_Rst_L low):
- State IDLE.
- o_Angle = 0, o_Angle_DV = 0, o_Error = 0, o_Busy = 0.
- r_Acc = 0, r_Count = 0, timeout counter = 0.

Latency:
- Terminator accepted on edge N (i_RX_DV high): o_Angle and o_Angle_DV update on the same edge, so both are visible in cycle N+1.
- o_Angle_DV lasts exactly one cycle.
- o_Error follows the same one-edge latency.

Byte handling:
- Back-to-back i_RX_DV on consecutive cycles must be handled without loss.
- Cycles with i_RX_DV low never change state, except through the timeout.

Timeout:
- The counter runs only in ACCUM and DISCARD.
- It clears on every i_RX_DV and on entry to IDLE.
- It fires when the count reaches TIMEOUT_CYCLES−1 with no byte.
- If a byte and the timeout coincide in the same cycle, the byte wins and the timeout counter clears.

Reset mid-command: the partial command is lost and the previous o_Angle is not retained (o_Angle returns to 0).

## Structure
Shared package `servo_pkg` holds:
- ASCII constants: zero, nine, CR, LF.
- The parser state enum.
- The 25 MHz clock-frequency constant used to derive TIMEOUT_CYCLES.

One sub-module is natural: `rx_timeout_timer`.
- Parameter: TIMEOUT_CYCLES.
- Inputs: run enable, clear.
- Output: one-cycle expiry pulse.
- Same clock and reset as the parser.

## Test plan
- "90\r\n" sent back-to-back → o_Angle = 90 with one o_Angle_DV pulse one cycle after the CR strobe; the LF causes no pulse and no error.
- "180\n", then "181\n" → first gives o_Angle = 180 with DV; second gives o_Error, and o_Angle stays 180.
- "1a5\n7\n" → o_Error on 'a', no pulse on that command's terminator, then o_Angle = 7 with DV.
- "0007\n" and "007\n" → error for the first; o_Angle = 7 for the second.
- "12", then idle for TIMEOUT_CYCLES (use a small parameter, e.g. 16) → o_Error, o_Busy drops; a following "3\n" gives o_Angle = 3.
- i_Rst_L pulsed low after "4" of "45\n" → all outputs return to 0 immediately; the trailing "5\n" then gives o_Angle = 5.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared definitions for the Bluetooth servo receive path: ASCII codes,
// parser state encoding and the system clock rate used to size timeouts.
package servo_pkg;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NINE = 8'h39;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    localparam int CLK_FREQ_HZ        = 25_000_000;
    // 100 ms of inter-byte silence abandons a partial command.
    localparam int RX_TIMEOUT_DEFAULT = CLK_FREQ_HZ / 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_DISCARD = 2'd2
    } parser_state_e;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
    endfunction

    function automatic logic is_term(input logic [7:0] b);
        return (b == ASCII_CR) || (b == ASCII_LF);
    endfunction

endpackage

// File: rtl/rx_timeout_timer.sv
// Inter-byte idle timer: counts while enabled, clears on any received byte,
// and pulses for one cycle once TIMEOUT_CYCLES idle cycles have elapsed.
module rx_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Run,
    input  logic i_Clear,
    output logic o_Expire
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_Cnt_q, r_Cnt_d;

    // A byte in the same cycle as the terminal count suppresses expiry.
    assign o_Expire = i_Run && !i_Clear && (r_Cnt_q == LAST);

    always_comb begin
        r_Cnt_d = r_Cnt_q + 1'b1;
        if (!i_Run || i_Clear || o_Expire) r_Cnt_d = '0;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) r_Cnt_q <= '0;
        else          r_Cnt_q <= r_Cnt_d;
    end

endmodule

// File: rtl/ascii_angle_parser.sv
// Turns CR/LF-terminated ASCII decimal commands from the UART into a
// range-checked 8-bit servo angle with one-cycle valid/error strobes.
module ascii_angle_parser
    import servo_pkg::*;
#(
    parameter int MAX_VALUE      = 180,
    parameter int MAX_DIGITS     = 3,
    parameter int TIMEOUT_CYCLES = RX_TIMEOUT_DEFAULT
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    output logic [7:0] o_Angle,
    output logic       o_Angle_DV,
    output logic       o_Error,
    output logic       o_Busy
);

    parser_state_e r_State_q, r_State_d;
    logic [9:0]    r_Acc_q, r_Acc_d;
    logic [1:0]    r_Count_q, r_Count_d;
    logic [7:0]    r_Angle_q, r_Angle_d;
    logic          r_DV_q, r_DV_d;
    logic          r_Err_q, r_Err_d;

    logic       w_Digit, w_Term, w_Expire;
    logic [3:0] w_Nib;
    logic [9:0] w_Acc_Next;

    assign w_Digit    = is_digit(i_RX_Byte);
    assign w_Term     = is_term(i_RX_Byte);
    assign w_Nib      = 4'(i_RX_Byte - ASCII_ZERO);
    // Only used while fewer than MAX_DIGITS are held, so at most 999: fits 10 bits.
    assign w_Acc_Next = (r_Acc_q * 10'd10) + {6'd0, w_Nib};

    rx_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Run   (r_State_q != ST_IDLE),
        .i_Clear (i_RX_DV),
        .o_Expire(w_Expire)
    );

    always_comb begin
        r_State_d = r_State_q;
        r_Acc_d   = r_Acc_q;
        r_Count_d = r_Count_q;
        r_Angle_d = r_Angle_q;
        r_DV_d    = 1'b0;
        r_Err_d   = 1'b0;
        case (r_State_q)
            ST_IDLE: begin
                if (i_RX_DV) begin
                    if (w_Digit) begin
                        r_Acc_d   = {6'd0, w_Nib};
                        r_Count_d = 2'd1;
                        r_State_d = ST_ACCUM;
                    end else if (!w_Term) begin
                        r_Err_d   = 1'b1;
                        r_State_d = ST_DISCARD;
                    end
                end
            end
            ST_ACCUM: begin
                if (i_RX_DV) begin
                    if (w_Digit) begin
                        if (int'(r_Count_q) < MAX_DIGITS) begin
                            r_Acc_d   = w_Acc_Next;
                            r_Count_d = r_Count_q + 2'd1;
                        end else begin
                            r_Err_d   = 1'b1;
                            r_State_d = ST_DISCARD;
                        end
                    end else if (w_Term) begin
                        if (int'(r_Acc_q) <= MAX_VALUE) begin
                            r_Angle_d = r_Acc_q[7:0];
                            r_DV_d    = 1'b1;
                        end else begin
                            r_Err_d   = 1'b1;
                        end
                        r_State_d = ST_IDLE;
                    end else begin
                        r_Err_d   = 1'b1;
                        r_State_d = ST_DISCARD;
                    end
                end else if (w_Expire) begin
                    r_Err_d   = 1'b1;
                    r_State_d = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                // The error was already reported on the offending byte.
                if (i_RX_DV) begin
                    if (w_Term) r_State_d = ST_IDLE;
                end else if (w_Expire) begin
                    r_State_d = ST_IDLE;
                end
            end
            default: r_State_d = ST_IDLE;
        endcase
        if (r_State_d == ST_IDLE) begin
            r_Acc_d   = '0;
            r_Count_d = '0;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_State_q <= ST_IDLE;
            r_Acc_q   <= '0;
            r_Count_q <= '0;
            r_Angle_q <= '0;
            r_DV_q    <= 1'b0;
            r_Err_q   <= 1'b0;
        end else begin
            r_State_q <= r_State_d;
            r_Acc_q   <= r_Acc_d;
            r_Count_q <= r_Count_d;
            r_Angle_q <= r_Angle_d;
            r_DV_q    <= r_DV_d;
            r_Err_q   <= r_Err_d;
        end
    end

    assign o_Angle    = r_Angle_q;
    assign o_Angle_DV = r_DV_q;
    assign o_Error    = r_Err_q;
    assign o_Busy     = (r_State_q != ST_IDLE);

endmodule
